reg_fifo_n: RTL and testbench



---
 rtl/reg_fifo_n.sv | 131 +++++++++++++
 tb/tb_reg_fifo_n.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_fifo_n.sv
// reg_fifo_n: register-based synchronous FIFO with a registered read port.
//
// Handshake: a load is accepted on a rising edge when load_i=1 and the FIFO
// is not full, or is full but an unload is accepted on that same edge. An
// unload is accepted when unload_i=1 and the FIFO is not empty. Its word
// appears on data_o after that edge, and valid_o is high for exactly that one
// cycle. An unload on an empty FIFO never bypasses a load made on the same edge.
// clr_i overrides both requests. full_o, empty_o and count_o come only from
// registered state.
//
// Optional feature: define REG_FIFO_N_ERR_EN to build sticky overflow and
// underflow flags (ovf_o/udf_o). Without it the flags are tied to 0 and
// have no registers.
module reg_fifo_n #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 load_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 unload_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [ADDR_SIZE:0]   count_o,
    output logic                 ovf_o,
    output logic                 udf_o
);

    localparam logic [ADDR_SIZE:0]   FULL_COUNT = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0]   COUNT_ONE  = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE    = ADDR_SIZE'(1);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   count;
    logic                 do_load;
    logic                 do_unload;

    assign full_o  = (count == FULL_COUNT);
    assign empty_o = (count == '0);
    assign count_o = count;

    // Acceptance decisions; a full FIFO can take a load when a read frees a slot.
    always_comb begin
        do_unload = unload_i && !empty_o;
        do_load   = load_i && (!full_o || do_unload);
    end

    // Storage array; no reset needed because pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_load && !clr_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy count; clear wins over both requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_load) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_unload) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_load, do_unload})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data_o holds its value unless an unload is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= do_unload;
            if (do_unload) begin
                data_o <= mem[rd_ptr];
            end
        end
    end

`ifdef REG_FIFO_N_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags: a dropped load sets ovf, a dropped unload sets udf.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clr_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (load_i && !do_load) begin
                ovf_q <= 1'b1;
            end
            if (unload_i && empty_o) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_reg_fifo_n.sv
// tb_reg_fifo_n: directed-vector bench for reg_fifo_n (DATA_SIZE=8, DEPTH=4).
// Unload requests push the hand-computed word into exp_q; a monitor on the
// falling edge pops and compares whenever valid_o is high.
module tb_reg_fifo_n;

    localparam int W = 8;

`ifdef REG_FIFO_N_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         load;
    logic [W-1:0] data_in;
    logic         unload;
    logic [W-1:0] data_out;
    logic         valid;
    logic         full;
    logic         empty;
    logic [2:0]   count;
    logic         ovf;
    logic         udf;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];

    reg_fifo_n #(
        .DATA_SIZE(8),
        .DEPTH(4),
        .ADDR_SIZE(2)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .load_i  (load),
        .data_i  (data_in),
        .unload_i(unload),
        .data_o  (data_out),
        .valid_o (valid),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count),
        .ovf_o   (ovf),
        .udf_o   (udf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // one clock of stimulus; returns at posedge+1 with inputs idle
    task automatic step(input logic l, input logic [W-1:0] d, input logic u, input logic c);
        load    = l;
        data_in = d;
        unload  = u;
        clr     = c;
        @(posedge clk);
        #1;
        load    = 1'b0;
        unload  = 1'b0;
        clr     = 1'b0;
        data_in = '0;
    endtask

    task automatic push(input logic [W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [W-1:0] exp);
        exp_q.push_back(exp);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // scoreboard monitor: every valid word must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got data 0x%0h, expected no valid", data_out);
            end else begin
                check("read_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b1;
        clr     = 1'b0;
        load    = 1'b0;
        unload  = 1'b0;
        data_in = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_valid", valid, 0);
        check("rst_data", data_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_udf", udf, 0);
        rst_n = 1'b1;

        // fill to full
        push(8'h11); check("fill_count1", count, 1); check("fill_empty", empty, 0);
        push(8'h22); check("fill_count2", count, 2);
        push(8'h33); check("fill_count3", count, 3); check("fill_not_full", full, 0);
        push(8'h44); check("fill_count4", count, 4); check("fill_full", full, 1);

        // load while full is dropped
        push(8'h55);
        check("ovf_count", count, 4);
        check("ovf_flag", ovf, ERR_EN);
        pop(8'h11); check("drain_count3", count, 3);
        pop(8'h22);
        pop(8'h33);
        pop(8'h44); check("drain_empty", empty, 1); check("drain_count0", count, 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("idle_valid", valid, 0);

        // unload while empty is dropped
        step(1'b0, '0, 1'b1, 1'b0);
        check("udf_valid", valid, 0);
        check("udf_data_held", data_out, 8'h44);
        check("udf_flag", udf, ERR_EN);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", ovf, 0);
        check("clr_udf", udf, 0);

        // empty: load and unload together, no bypass
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        check("nobypass_count", count, 1);
        check("nobypass_valid", valid, 0);
        check("nobypass_data", data_out, 8'h44);
        check("nobypass_udf", udf, ERR_EN);
        pop(8'hA5); check("nobypass_after", count, 0);
        step(1'b0, '0, 1'b0, 1'b1);

        // full: simultaneous load/unload with pointer wrap
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("full2_full", full, 1);
        exp_q.push_back(8'h11);
        step(1'b1, 8'h66, 1'b1, 1'b0);
        check("rw_full_count", count, 4);
        check("rw_full_ovf", ovf, 0);
        pop(8'h22);
        pop(8'h33);
        pop(8'h44);
        pop(8'h66); check("wrap_empty", empty, 1);

        // clear with both requests high
        step(1'b0, '0, 1'b1, 1'b0);
        check("pre_clr_udf", udf, ERR_EN);
        push(8'h81); push(8'h82);
        check("pre_clr_count", count, 2);
        step(1'b1, 8'h83, 1'b1, 1'b1);
        check("clr_count", count, 0);
        check("clr_empty", empty, 1);
        check("clr_valid", valid, 0);
        check("clr_data_held", data_out, 8'h66);
        check("clr_udf2", udf, 0);
        check("clr_ovf2", ovf, 0);

        // asynchronous reset mid-operation
        push(8'h91); push(8'h92); push(8'h93);
        check("pre_rst_count", count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_full", full, 0);
        check("async_rst_data", data_out, 0);
        check("async_rst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'h77); check("post_rst_count", count, 1);
        pop(8'h77); check("post_rst_empty", empty, 1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_reads: %0d words never appeared, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
